// File: rtl/mem_access_stage.sv
// MiniMIPS32 memory-access stage: issues aligned loads/stores to a handshaked data memory,
// stalls the pipeline while the access is outstanding, and drives the MEM/WB register.
module mem_access_stage (
  input  logic        cpu_clk_50M,
  input  logic        cpu_rst,
  input  logic [7:0]  mem_aluop,
  input  logic [4:0]  mem_wa,
  input  logic        mem_wreg,
  input  logic        mem_mreg,
  input  logic [31:0] mem_wd,
  input  logic [31:0] mem_din,
  input  logic        mem_whilo,
  input  logic [63:0] mem_hilo,
  output logic        dm_req,
  output logic        dm_we,
  output logic [3:0]  dm_be,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  input  logic        dm_ack,
  input  logic [31:0] dm_rdata,
  output logic        stallreq_mem,
  output logic        mem_adel,
  output logic        mem_ades,
  output logic [4:0]  wb_wa,
  output logic        wb_wreg,
  output logic [31:0] wb_wd,
  output logic        wb_whilo,
  output logic [63:0] wb_hilo
);

  localparam logic [7:0] OP_LB  = 8'h90;
  localparam logic [7:0] OP_LBU = 8'h91;
  localparam logic [7:0] OP_LH  = 8'h92;
  localparam logic [7:0] OP_LHU = 8'h93;
  localparam logic [7:0] OP_LW  = 8'h94;
  localparam logic [7:0] OP_SB  = 8'h98;
  localparam logic [7:0] OP_SH  = 8'h99;
  localparam logic [7:0] OP_SW  = 8'h9A;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_r;
  state_t      state_nxt_s;
  logic        is_load_s;
  logic        is_store_s;
  logic        misalign_s;
  logic        issue_s;
  logic        stall_s;
  logic [1:0]  off_r;
  logic [31:0] load_buf_r;
  logic [4:0]  wb_wa_nxt_s;
  logic        wb_wreg_nxt_s;
  logic [31:0] wb_wd_nxt_s;
  logic        wb_whilo_nxt_s;
  logic [63:0] wb_hilo_nxt_s;

  function automatic logic op_is_load(input logic [7:0] op);
    case (op)
      OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW: op_is_load = 1'b1;
      default:                             op_is_load = 1'b0;
    endcase
  endfunction

  function automatic logic op_is_store(input logic [7:0] op);
    case (op)
      OP_SB, OP_SH, OP_SW: op_is_store = 1'b1;
      default:             op_is_store = 1'b0;
    endcase
  endfunction

  function automatic logic op_misaligned(input logic [7:0] op, input logic [1:0] lo);
    case (op)
      OP_LH, OP_LHU, OP_SH: op_misaligned = lo[0];
      OP_LW, OP_SW:         op_misaligned = (lo != 2'b00);
      default:              op_misaligned = 1'b0;
    endcase
  endfunction

  // Byte lanes touched by the access; loads use the same lane mask as stores of equal size.
  function automatic logic [3:0] access_be(input logic [7:0] op, input logic [1:0] lo);
    case (op)
      OP_LB, OP_LBU, OP_SB: access_be = 4'b0001 << lo;
      OP_LH, OP_LHU, OP_SH: access_be = lo[1] ? 4'b1100 : 4'b0011;
      OP_LW, OP_SW:         access_be = 4'b1111;
      default:              access_be = 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] store_data(input logic [7:0] op, input logic [31:0] din);
    case (op)
      OP_SB:   store_data = {4{din[7:0]}};
      OP_SH:   store_data = {2{din[15:0]}};
      OP_SW:   store_data = din;
      default: store_data = 32'h0000_0000;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(input logic [7:0] op, input logic [1:0] lo,
                                              input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    case (lo)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      2'd3:    b = word[31:24];
      default: b = word[7:0];
    endcase
    h = lo[1] ? word[31:16] : word[15:0];
    case (op)
      OP_LB:   load_extend = {{24{b[7]}}, b};
      OP_LBU:  load_extend = {24'h00_0000, b};
      OP_LH:   load_extend = {{16{h[15]}}, h};
      OP_LHU:  load_extend = {16'h0000, h};
      default: load_extend = word;
    endcase
  endfunction

  // Operation decode
  always_comb begin
    is_load_s  = op_is_load(mem_aluop);
    is_store_s = op_is_store(mem_aluop);
    misalign_s = op_misaligned(mem_aluop, mem_wd[1:0]);
  end

  // FSM state register
  always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
    if (cpu_rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE:    state_nxt_s = issue_s ? BUSY : IDLE;
      BUSY:    state_nxt_s = dm_ack ? DONE : BUSY;
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // FSM outputs: the stall covers the issuing IDLE cycle and every BUSY cycle
  always_comb begin
    issue_s = 1'b0;
    stall_s = 1'b0;
    case (state_r)
      IDLE: begin
        issue_s = (is_load_s || is_store_s) && !misalign_s;
        stall_s = issue_s;
      end
      BUSY: begin
        issue_s = 1'b0;
        stall_s = 1'b1;
      end
      DONE: begin
        issue_s = 1'b0;
        stall_s = 1'b0;
      end
      default: begin
        issue_s = 1'b0;
        stall_s = 1'b0;
      end
    endcase
  end

  assign stallreq_mem = stall_s;

  // Data-memory request registers, held stable from issue until the ack
  always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
    if (cpu_rst) begin
      dm_req   <= 1'b0;
      dm_we    <= 1'b0;
      dm_be    <= 4'b0000;
      dm_addr  <= 32'h0000_0000;
      dm_wdata <= 32'h0000_0000;
      off_r    <= 2'b00;
    end else if (issue_s) begin
      dm_req   <= 1'b1;
      dm_we    <= is_store_s;
      dm_be    <= access_be(mem_aluop, mem_wd[1:0]);
      dm_addr  <= {mem_wd[31:2], 2'b00};
      dm_wdata <= store_data(mem_aluop, mem_din);
      off_r    <= mem_wd[1:0];
    end else if ((state_r == BUSY) && dm_ack) begin
      dm_req   <= 1'b0;
    end else begin
      dm_req   <= dm_req;
    end
  end

  // Read-data buffer, captured only on an ack during BUSY
  always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
    if (cpu_rst) begin
      load_buf_r <= 32'h0000_0000;
    end else if ((state_r == BUSY) && dm_ack) begin
      load_buf_r <= dm_rdata;
    end else begin
      load_buf_r <= load_buf_r;
    end
  end

  // Address-error pulses, one cycle per misaligned op seen in IDLE
  always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
    if (cpu_rst) begin
      mem_adel <= 1'b0;
      mem_ades <= 1'b0;
    end else begin
      mem_adel <= (state_r == IDLE) && is_load_s && misalign_s;
      mem_ades <= (state_r == IDLE) && is_store_s && misalign_s;
    end
  end

  // MEM/WB next value: bubble while stalled or faulting, pass-through otherwise
  always_comb begin
    wb_wa_nxt_s    = 5'd0;
    wb_wreg_nxt_s  = 1'b0;
    wb_wd_nxt_s    = 32'h0000_0000;
    wb_whilo_nxt_s = 1'b0;
    wb_hilo_nxt_s  = 64'h0;
    case (state_r)
      IDLE: begin
        if (is_load_s || is_store_s) begin
          wb_wreg_nxt_s  = 1'b0;
          wb_whilo_nxt_s = 1'b0;
        end else begin
          wb_wa_nxt_s    = mem_wa;
          wb_wreg_nxt_s  = mem_wreg;
          wb_wd_nxt_s    = mem_wd;
          wb_whilo_nxt_s = mem_whilo;
          wb_hilo_nxt_s  = mem_hilo;
        end
      end
      BUSY: begin
        wb_wreg_nxt_s  = 1'b0;
        wb_whilo_nxt_s = 1'b0;
      end
      DONE: begin
        wb_wa_nxt_s   = mem_wa;
        wb_hilo_nxt_s = mem_hilo;
        if (is_store_s) begin
          wb_wreg_nxt_s  = 1'b0;
          wb_whilo_nxt_s = 1'b0;
          wb_wd_nxt_s    = mem_wd;
        end else begin
          wb_wreg_nxt_s  = mem_wreg;
          wb_whilo_nxt_s = mem_whilo;
          wb_wd_nxt_s    = mem_mreg ? load_extend(mem_aluop, off_r, load_buf_r) : mem_wd;
        end
      end
      default: begin
        wb_wreg_nxt_s  = 1'b0;
        wb_whilo_nxt_s = 1'b0;
      end
    endcase
  end

  // MEM/WB register
  always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
    if (cpu_rst) begin
      wb_wa    <= 5'd0;
      wb_wreg  <= 1'b0;
      wb_wd    <= 32'h0000_0000;
      wb_whilo <= 1'b0;
      wb_hilo  <= 64'h0;
    end else begin
      wb_wa    <= wb_wa_nxt_s;
      wb_wreg  <= wb_wreg_nxt_s;
      wb_wd    <= wb_wd_nxt_s;
      wb_whilo <= wb_whilo_nxt_s;
      wb_hilo  <= wb_hilo_nxt_s;
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed self-checking bench for mem_access_stage: loads, stores, misalignment,
// back-to-back flow and reset during an outstanding access.
module tb_mem_access_stage;

  localparam logic [7:0] OP_NOP = 8'h00;
  localparam logic [7:0] OP_ADD = 8'h18;
  localparam logic [7:0] OP_LB  = 8'h90;
  localparam logic [7:0] OP_LBU = 8'h91;
  localparam logic [7:0] OP_LH  = 8'h92;
  localparam logic [7:0] OP_LHU = 8'h93;
  localparam logic [7:0] OP_LW  = 8'h94;
  localparam logic [7:0] OP_SB  = 8'h98;
  localparam logic [7:0] OP_SH  = 8'h99;
  localparam logic [7:0] OP_SW  = 8'h9A;

  logic        cpu_clk_50M = 1'b0;
  logic        cpu_rst;
  logic [7:0]  mem_aluop;
  logic [4:0]  mem_wa;
  logic        mem_wreg;
  logic        mem_mreg;
  logic [31:0] mem_wd;
  logic [31:0] mem_din;
  logic        mem_whilo;
  logic [63:0] mem_hilo;
  logic        dm_req;
  logic        dm_we;
  logic [3:0]  dm_be;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_ack;
  logic [31:0] dm_rdata;
  logic        stallreq_mem;
  logic        mem_adel;
  logic        mem_ades;
  logic [4:0]  wb_wa;
  logic        wb_wreg;
  logic [31:0] wb_wd;
  logic        wb_whilo;
  logic [63:0] wb_hilo;

  int checks = 0;
  int errors = 0;

  mem_access_stage dut (
    .cpu_clk_50M (cpu_clk_50M),
    .cpu_rst     (cpu_rst),
    .mem_aluop   (mem_aluop),
    .mem_wa      (mem_wa),
    .mem_wreg    (mem_wreg),
    .mem_mreg    (mem_mreg),
    .mem_wd      (mem_wd),
    .mem_din     (mem_din),
    .mem_whilo   (mem_whilo),
    .mem_hilo    (mem_hilo),
    .dm_req      (dm_req),
    .dm_we       (dm_we),
    .dm_be       (dm_be),
    .dm_addr     (dm_addr),
    .dm_wdata    (dm_wdata),
    .dm_ack      (dm_ack),
    .dm_rdata    (dm_rdata),
    .stallreq_mem(stallreq_mem),
    .mem_adel    (mem_adel),
    .mem_ades    (mem_ades),
    .wb_wa       (wb_wa),
    .wb_wreg     (wb_wreg),
    .wb_wd       (wb_wd),
    .wb_whilo    (wb_whilo),
    .wb_hilo     (wb_hilo)
  );

  always #5 cpu_clk_50M = ~cpu_clk_50M;

  task automatic tick();
    @(posedge cpu_clk_50M);
    #1;
  endtask

  task automatic set_op(input logic [7:0] op, input logic [4:0] wa, input logic wreg,
                        input logic mreg, input logic [31:0] wd, input logic [31:0] din,
                        input logic whilo, input logic [63:0] hilo);
    mem_aluop = op;
    mem_wa    = wa;
    mem_wreg  = wreg;
    mem_mreg  = mreg;
    mem_wd    = wd;
    mem_din   = din;
    mem_whilo = whilo;
    mem_hilo  = hilo;
  endtask

  task automatic test_reset();
    cpu_rst  = 1'b1;
    dm_ack   = 1'b0;
    dm_rdata = 32'h0;
    set_op(OP_NOP, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 64'h0);
    tick();
    tick();
    checks++;
    if ({dm_req, dm_we, dm_be, dm_addr, dm_wdata} !== 70'h0) begin
      errors++; $display("FAIL reset_dm got req=%0h be=%0h addr=%0h exp all zero", dm_req, dm_be, dm_addr);
    end
    checks++;
    if ({stallreq_mem, mem_adel, mem_ades, wb_wa, wb_wreg, wb_wd, wb_whilo, wb_hilo} !== 106'h0) begin
      errors++; $display("FAIL reset_wb got wreg=%0h wd=%0h stall=%0h exp all zero", wb_wreg, wb_wd, stallreq_mem);
    end
    cpu_rst = 1'b0;
  endtask

  task automatic test_lw_wait();
    int stall_cycles;
    stall_cycles = 0;
    set_op(OP_LW, 5'd3, 1'b1, 1'b1, 32'h0000_1004, 32'h0, 1'b0, 64'h0);
    #1;
    if (stallreq_mem === 1'b1) stall_cycles++;
    tick();
    checks++;
    if (dm_req !== 1'b1 || dm_we !== 1'b0 || dm_be !== 4'b1111 || dm_addr !== 32'h0000_1004) begin
      errors++; $display("FAIL lw_issue got req=%0h we=%0h be=%0h addr=%0h exp 1 0 f 1004", dm_req, dm_we, dm_be, dm_addr);
    end
    if (stallreq_mem === 1'b1) stall_cycles++;
    tick();
    checks++;
    if (dm_req !== 1'b1 || dm_addr !== 32'h0000_1004 || wb_wreg !== 1'b0) begin
      errors++; $display("FAIL lw_hold got req=%0h addr=%0h wb_wreg=%0h exp 1 1004 0", dm_req, dm_addr, wb_wreg);
    end
    if (stallreq_mem === 1'b1) stall_cycles++;
    dm_ack   = 1'b1;
    dm_rdata = 32'hDEAD_BEEF;
    tick();
    dm_ack   = 1'b0;
    dm_rdata = 32'h0;
    checks++;
    if (dm_req !== 1'b0 || stallreq_mem !== 1'b0 || wb_wreg !== 1'b0) begin
      errors++; $display("FAIL lw_done got req=%0h stall=%0h wb_wreg=%0h exp 0 0 0", dm_req, stallreq_mem, wb_wreg);
    end
    if (stallreq_mem === 1'b1) stall_cycles++;
    checks++;
    if (stall_cycles !== 3) begin
      errors++; $display("FAIL lw_stall_cycles got %0d exp 3", stall_cycles);
    end
    tick();
    checks++;
    if (wb_wd !== 32'hDEAD_BEEF || wb_wreg !== 1'b1 || wb_wa !== 5'd3) begin
      errors++; $display("FAIL lw_wb got wd=%0h wreg=%0h wa=%0d exp deadbeef 1 3", wb_wd, wb_wreg, wb_wa);
    end
    set_op(OP_NOP, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 64'h0);
  endtask

  task automatic test_load_extend();
    logic [7:0]  ops  [6] = '{OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LB, OP_LW};
    logic [31:0] addrs[6] = '{32'h2003, 32'h2003, 32'h2002, 32'h2000, 32'h2001, 32'h2000};
    logic [31:0] rds  [6] = '{32'h8000_0000, 32'h8000_0000, 32'h8001_0000,
                              32'h1234_ABCD, 32'h0000_7F00, 32'hCAFE_F00D};
    logic [31:0] exps [6] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8001,
                              32'h0000_ABCD, 32'h0000_007F, 32'hCAFE_F00D};
    logic [3:0]  bes  [6] = '{4'b1000, 4'b1000, 4'b1100, 4'b0011, 4'b0010, 4'b1111};
    for (int i = 0; i < 6; i++) begin
      set_op(ops[i], 5'd5, 1'b1, 1'b1, addrs[i], 32'h0, 1'b0, 64'h0);
      tick();
      checks++;
      if (dm_be !== bes[i] || dm_addr !== 32'h0000_2000) begin
        errors++; $display("FAIL ld_be[%0d] got be=%0h addr=%0h exp %0h 2000", i, dm_be, dm_addr, bes[i]);
      end
      dm_ack   = 1'b1;
      dm_rdata = rds[i];
      tick();
      dm_ack   = 1'b0;
      dm_rdata = 32'h0;
      tick();
      checks++;
      if (wb_wd !== exps[i] || wb_wreg !== 1'b1) begin
        errors++; $display("FAIL ld_ext[%0d] got wd=%0h wreg=%0h exp %0h 1", i, wb_wd, wb_wreg, exps[i]);
      end
      set_op(OP_NOP, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 64'h0);
      tick();
    end
  endtask

  task automatic test_store();
    logic [7:0]  ops  [3] = '{OP_SH, OP_SB, OP_SW};
    logic [31:0] addrs[3] = '{32'h3002, 32'h3001, 32'h3004};
    logic [31:0] dins [3] = '{32'h0000_1234, 32'h0000_00AB, 32'h1122_3344};
    logic [31:0] wdats[3] = '{32'h1234_1234, 32'hABAB_ABAB, 32'h1122_3344};
    logic [3:0]  bes  [3] = '{4'b1100, 4'b0010, 4'b1111};
    logic [31:0] waddr[3] = '{32'h3000, 32'h3000, 32'h3004};
    for (int i = 0; i < 3; i++) begin
      set_op(ops[i], 5'd7, 1'b1, 1'b0, addrs[i], dins[i], 1'b1, 64'h55);
      tick();
      checks++;
      if (dm_req !== 1'b1 || dm_we !== 1'b1 || dm_be !== bes[i] || dm_wdata !== wdats[i] || dm_addr !== waddr[i]) begin
        errors++; $display("FAIL st_issue[%0d] got we=%0h be=%0h wdata=%0h addr=%0h exp 1 %0h %0h %0h",
                           i, dm_we, dm_be, dm_wdata, dm_addr, bes[i], wdats[i], waddr[i]);
      end
      dm_ack = 1'b1;
      tick();
      dm_ack = 1'b0;
      tick();
      checks++;
      if (wb_wreg !== 1'b0 || wb_whilo !== 1'b0 || dm_req !== 1'b0) begin
        errors++; $display("FAIL st_wb[%0d] got wreg=%0h whilo=%0h req=%0h exp 0 0 0", i, wb_wreg, wb_whilo, dm_req);
      end
      set_op(OP_NOP, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 64'h0);
      tick();
    end
  endtask

  task automatic test_misaligned();
    set_op(OP_LW, 5'd9, 1'b1, 1'b1, 32'h0000_4001, 32'h0, 1'b0, 64'h0);
    #1;
    checks++;
    if (stallreq_mem !== 1'b0) begin
      errors++; $display("FAIL mis_lw_stall got %0h exp 0", stallreq_mem);
    end
    tick();
    checks++;
    if (dm_req !== 1'b0 || mem_adel !== 1'b1 || mem_ades !== 1'b0 || wb_wreg !== 1'b0) begin
      errors++; $display("FAIL mis_lw got req=%0h adel=%0h ades=%0h wreg=%0h exp 0 1 0 0", dm_req, mem_adel, mem_ades, wb_wreg);
    end
    set_op(OP_SH, 5'd9, 1'b0, 1'b0, 32'h0000_4003, 32'h0000_BEEF, 1'b1, 64'h1);
    tick();
    checks++;
    if (mem_adel !== 1'b0 || mem_ades !== 1'b1 || dm_req !== 1'b0 || wb_whilo !== 1'b0) begin
      errors++; $display("FAIL mis_sh got adel=%0h ades=%0h req=%0h whilo=%0h exp 0 1 0 0", mem_adel, mem_ades, dm_req, wb_whilo);
    end
    set_op(OP_NOP, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 64'h0);
    tick();
    checks++;
    if (mem_adel !== 1'b0 || mem_ades !== 1'b0) begin
      errors++; $display("FAIL mis_pulse_end got adel=%0h ades=%0h exp 0 0", mem_adel, mem_ades);
    end
  endtask

  task automatic test_back_to_back();
    set_op(OP_ADD, 5'd1, 1'b1, 1'b0, 32'h11, 32'h0, 1'b1, 64'h0123_4567_89AB_CDEF);
    #1;
    checks++;
    if (stallreq_mem !== 1'b0) begin
      errors++; $display("FAIL b2b_add_stall got %0h exp 0", stallreq_mem);
    end
    tick();
    checks++;
    if (wb_wa !== 5'd1 || wb_wd !== 32'h11 || wb_wreg !== 1'b1 || wb_whilo !== 1'b1 || wb_hilo !== 64'h0123_4567_89AB_CDEF) begin
      errors++; $display("FAIL b2b_add1 got wa=%0d wd=%0h wreg=%0h hilo=%0h exp 1 11 1 123456789abcdef", wb_wa, wb_wd, wb_wreg, wb_hilo);
    end
    set_op(OP_SW, 5'd0, 1'b0, 1'b0, 32'h0000_5000, 32'h99, 1'b0, 64'h0);
    tick();
    checks++;
    if (wb_wreg !== 1'b0 || wb_wd !== 32'h0 || stallreq_mem !== 1'b1) begin
      errors++; $display("FAIL b2b_bubble got wreg=%0h wd=%0h stall=%0h exp 0 0 1", wb_wreg, wb_wd, stallreq_mem);
    end
    dm_ack = 1'b1;
    tick();
    dm_ack = 1'b0;
    tick();
    set_op(OP_ADD, 5'd2, 1'b1, 1'b0, 32'h22, 32'h0, 1'b0, 64'h0);
    tick();
    checks++;
    if (wb_wa !== 5'd2 || wb_wd !== 32'h22 || wb_wreg !== 1'b1) begin
      errors++; $display("FAIL b2b_add2 got wa=%0d wd=%0h wreg=%0h exp 2 22 1", wb_wa, wb_wd, wb_wreg);
    end
    set_op(OP_NOP, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 64'h0);
    tick();
    checks++;
    if (wb_wreg !== 1'b0) begin
      errors++; $display("FAIL b2b_no_dup got wreg=%0h exp 0", wb_wreg);
    end
  endtask

  task automatic test_reset_mid_busy();
    set_op(OP_LW, 5'd4, 1'b1, 1'b1, 32'h0000_6000, 32'h0, 1'b0, 64'h0);
    tick();
    checks++;
    if (dm_req !== 1'b1) begin
      errors++; $display("FAIL rst_busy_req got %0h exp 1", dm_req);
    end
    #2;
    cpu_rst = 1'b1;
    set_op(OP_ADD, 5'd6, 1'b1, 1'b1, 32'h77, 32'h0, 1'b0, 64'h0);
    #1;
    checks++;
    if (dm_req !== 1'b0 || dm_be !== 4'b0000 || dm_addr !== 32'h0 || {wb_wa, wb_wreg, wb_wd, wb_whilo, wb_hilo} !== 103'h0) begin
      errors++; $display("FAIL rst_async got req=%0h be=%0h addr=%0h wreg=%0h exp all zero", dm_req, dm_be, dm_addr, wb_wreg);
    end
    tick();
    cpu_rst = 1'b0;
    #1;
    checks++;
    if (stallreq_mem !== 1'b0) begin
      errors++; $display("FAIL rst_idle_stall got %0h exp 0", stallreq_mem);
    end
    dm_ack   = 1'b1;
    dm_rdata = 32'h0000_0BAD;
    tick();
    dm_ack   = 1'b0;
    dm_rdata = 32'h0;
    checks++;
    if (dm_req !== 1'b0 || stallreq_mem !== 1'b0 || wb_wd !== 32'h77 || wb_wa !== 5'd6) begin
      errors++; $display("FAIL rst_stray_ack got req=%0h stall=%0h wd=%0h wa=%0d exp 0 0 77 6", dm_req, stallreq_mem, wb_wd, wb_wa);
    end
    tick();
    checks++;
    if (wb_wd !== 32'h77 || dm_req !== 1'b0) begin
      errors++; $display("FAIL rst_no_wb got wd=%0h req=%0h exp 77 0", wb_wd, dm_req);
    end
    set_op(OP_NOP, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 64'h0);
  endtask

  initial begin
    test_reset();
    test_lw_wait();
    test_load_extend();
    test_store();
    test_misaligned();
    test_back_to_back();
    test_reset_mid_busy();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
